rob_ring: RTL and testbench
===========================

# rob_ring

Parametrised, clocked re-order buffer for the out-of-order core, sitting between dispatch/rename and the register-file/free-list.
- Accepts up to DISPATCH_W renamed instructions per cycle in program order.
- Records up to CMPL_W tag-addressed functional-unit completions per cycle.
- Retires up to RETIRE_W completed instructions per cycle from the head, in order, returning each old physical register to the free list.
- Completions are looked up by ROB tag, not by searching on physical register.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥ 4.
- DISPATCH_W, 2, dispatch lanes.
- CMPL_W, 3, completion ports (one per FU).
- RETIRE_W, 2, retire lanes; ≤ DEPTH.
- PREG_W, 6, physical register index width.
- DATA_W, 32, result width.
- TAG_W, $clog2(DEPTH), derived.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
  - clk  in  1  rising-edge clock.
  - reset  in  1  asynchronous, active-high reset.
- disp_valid  in  DISPATCH_W  per-lane dispatch request.
- disp_is_store  in  DISPATCH_W  lane is SW (opcode 0100011).
- disp_preg  in  DISPATCH_W*PREG_W  new destination physical reg.
- disp_old_preg  in  DISPATCH_W*PREG_W  previous mapping of the destination.
- disp_ready  out  DISPATCH_W  lane k may be accepted this cycle.
- disp_tag  out  DISPATCH_W*TAG_W  tag assigned to lane k.
- cmpl_valid  in  CMPL_W  completion strobe.
- cmpl_tag  in  CMPL_W*TAG_W  completing entry.
- cmpl_data  in  CMPL_W*DATA_W  result.
- ret_valid  out  RETIRE_W  lane retires this cycle.
- ret_is_store  out  RETIRE_W  retiring entry is a store.
- ret_free  out  RETIRE_W  old_preg to be freed (ret_valid & ~store).
- ret_old_preg  out  RETIRE_W*PREG_W  register returned to the free list.
- ret_preg  out  RETIRE_W*PREG_W  committed physical reg.
- ret_data  out  RETIRE_W*DATA_W  committed result.
- count  out  $clog2(DEPTH+1)  occupied entries.
- flush  in  1  present only with ROB_FLUSH_EN.

## Operation
Per-entry state: v, comp, is_store, preg, old_preg, result.
Pointers and count: head, tail (TAG_W, wrap mod DEPTH), count.

Dispatch:
- disp_ready[k] = (DEPTH − count) > k.
- disp_tag[k] = tail + k.
- Lane k is accepted iff disp_valid[0..k] are all 1 and disp_ready[k] is 1. A gap stops acceptance of all higher lanes.
- Accepted lanes write v=1, comp=0, fields; tail advances by the number accepted.

Completion:
- For each port with cmpl_valid, when entry[cmpl_tag].v=1: set comp=1 and write result.
- A completion to an invalid entry is ignored.
- Two ports targeting the same tag: the highest port index wins.

Retire:
- Lane j is valid iff entries head..head+j are all v&comp (prefix rule) and j < count.
- Outputs are combinational from registered state.
- At the edge, retired entries clear v/comp; head advances by the retire count.

Count:
- count_next = count + n_disp − n_ret.
- Free space seen by dispatch ignores same-cycle retires, so the structure never over-fills.

## Timing
- Reset (async): all v=0, head=tail=count=0. Outputs: disp_ready all 1, ret_* all 0, disp_tag lane k = k, count=0.
- Dispatch accepted at edge N → entry visible from N.
- Earliest completion edge is N+1. The entry's comp is visible after that edge, so ret_valid can first be high in cycle N+1 → minimum dispatch-to-retire latency is 2 edges.
- Completion and retire of the same entry in one cycle: the retire uses the pre-edge comp, so no bypass.
- Full (count=DEPTH): disp_ready=0. Empty: ret_valid=0.
- Simultaneous dispatch into slots being freed by same-cycle retire: not allowed (free space excludes them).
- Wrap-around: tags and pointers roll DEPTH−1→0 with no bubble.
- Reset mid-operation discards all entries immediately, without waiting for an edge.

## Configuration
- ROB_FLUSH_EN defined: the flush port exists.
  - flush=1 at an edge clears all v/comp and sets head=tail=count=0.
  - Same-cycle dispatch and completion are ignored.
  - ret_valid, ret_free and disp_ready are forced 0 while flush=1.
- ROB_FLUSH_EN undefined: no flush port; the only way to clear the buffer is reset.

## Test plan
- Reset, dispatch 2 lanes (preg 33/34, old 1/2), complete tags 0,1 next cycle → following cycle ret_valid=11, ret_old_preg=1,2, count 2→0.
- Fill 16 entries in 8 cycles → count=16, disp_ready=00. Retire 1 → next cycle disp_ready=01 only.
- Complete tag 1 before tag 0 → no retire. Complete tag 0 → tags 0 and 1 retire together, in order.
- Dispatch a store on lane 0 and an ALU op on lane 1, complete both → ret_is_store=01, ret_free=10.
- Run 40 dispatch/complete/retire cycles → tags wrap 15→0, data matches a scoreboard, and a completion on an invalid tag is ignored.
- ROB_FLUSH_EN: with 5 valid entries, flush alongside disp_valid=11 → count=0 next cycle, no retires.

Source files
------------

// File: rtl/rob_ring.sv
// rob_ring: circular re-order buffer with tag-addressed completion and in-order multi-lane retire.
// Optional macro ROB_FLUSH_EN adds flush_i, which empties the buffer at the next edge.
module rob_ring #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DISPATCH_W = 2,
  parameter int unsigned CMPL_W     = 3,
  parameter int unsigned RETIRE_W   = 2,
  parameter int unsigned PREG_W     = 6,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TAG_W      = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef ROB_FLUSH_EN
  input  logic                           flush_i,
`endif
  input  logic [DISPATCH_W-1:0]          disp_valid_i,
  input  logic [DISPATCH_W-1:0]          disp_is_store_i,
  input  logic [DISPATCH_W*PREG_W-1:0]   disp_preg_i,
  input  logic [DISPATCH_W*PREG_W-1:0]   disp_old_preg_i,
  output logic [DISPATCH_W-1:0]          disp_ready_o,
  output logic [DISPATCH_W*TAG_W-1:0]    disp_tag_o,
  input  logic [CMPL_W-1:0]              cmpl_valid_i,
  input  logic [CMPL_W*TAG_W-1:0]        cmpl_tag_i,
  input  logic [CMPL_W*DATA_W-1:0]       cmpl_data_i,
  output logic [RETIRE_W-1:0]            ret_valid_o,
  output logic [RETIRE_W-1:0]            ret_is_store_o,
  output logic [RETIRE_W-1:0]            ret_free_o,
  output logic [RETIRE_W*PREG_W-1:0]     ret_old_preg_o,
  output logic [RETIRE_W*PREG_W-1:0]     ret_preg_o,
  output logic [RETIRE_W*DATA_W-1:0]     ret_data_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  v_q, v_d, comp_q, comp_d, st_q, st_d;
  logic [PREG_W-1:0] preg_q [DEPTH];
  logic [PREG_W-1:0] preg_d [DEPTH];
  logic [PREG_W-1:0] old_q  [DEPTH];
  logic [PREG_W-1:0] old_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic                  flush_c;
  logic [CNT_W-1:0]      free_c, n_disp_c, n_ret_c;
  logic [DISPATCH_W-1:0] acc_c;

`ifdef ROB_FLUSH_EN
  assign flush_c = flush_i;
`else
  assign flush_c = 1'b0;
`endif

  assign count_o = count_q;

  // Dispatch: free space ignores same-cycle retires; acceptance stops at the first gap.
  always_comb begin
    logic ok;
    ok           = ~flush_c;
    free_c       = CNT_W'(DEPTH) - count_q;
    n_disp_c     = '0;
    acc_c        = '0;
    disp_ready_o = '0;
    disp_tag_o   = '0;
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      disp_ready_o[k]              = ~flush_c & (32'(free_c) > k);
      ok                           = ok & disp_valid_i[k] & (32'(free_c) > k);
      acc_c[k]                     = ok;
      n_disp_c                     = n_disp_c + CNT_W'(ok);
      disp_tag_o[k*TAG_W +: TAG_W] = tail_q + TAG_W'(k);
    end
  end

  // Retire: a contiguous run of completed entries from head, straight from registered state.
  always_comb begin
    logic             ok;
    logic [TAG_W-1:0] idx;
    ok             = ~flush_c;
    idx            = '0;
    n_ret_c        = '0;
    ret_valid_o    = '0;
    ret_is_store_o = '0;
    ret_free_o     = '0;
    ret_old_preg_o = '0;
    ret_preg_o     = '0;
    ret_data_o     = '0;
    for (int unsigned j = 0; j < RETIRE_W; j++) begin
      idx               = head_q + TAG_W'(j);
      ok                = ok & v_q[idx] & comp_q[idx] & (32'(count_q) > j);
      ret_valid_o[j]    = ok;
      ret_is_store_o[j] = ok & st_q[idx];
      ret_free_o[j]     = ok & ~st_q[idx];
      ret_old_preg_o[j*PREG_W +: PREG_W] = ok ? old_q[idx]  : '0;
      ret_preg_o[j*PREG_W +: PREG_W]     = ok ? preg_q[idx] : '0;
      ret_data_o[j*DATA_W +: DATA_W]     = ok ? data_q[idx] : '0;
      n_ret_c = n_ret_c + CNT_W'(ok);
    end
  end

  // Next state: completions, then retire clears, then dispatch writes; flush overrides all.
  always_comb begin
    logic [TAG_W-1:0] idx;
    logic [TAG_W-1:0] ctag;
    v_d     = v_q;
    comp_d  = comp_q;
    st_d    = st_q;
    preg_d  = preg_q;
    old_d   = old_q;
    data_d  = data_q;
    idx     = '0;
    ctag    = '0;
    for (int unsigned p = 0; p < CMPL_W; p++) begin
      ctag = cmpl_tag_i[p*TAG_W +: TAG_W];
      if (cmpl_valid_i[p] && v_q[ctag]) begin
        comp_d[ctag] = 1'b1;
        data_d[ctag] = cmpl_data_i[p*DATA_W +: DATA_W];
      end
    end
    for (int unsigned j = 0; j < RETIRE_W; j++) begin
      idx = head_q + TAG_W'(j);
      if (ret_valid_o[j]) begin
        v_d[idx]    = 1'b0;
        comp_d[idx] = 1'b0;
      end
    end
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      idx = tail_q + TAG_W'(k);
      if (acc_c[k]) begin
        v_d[idx]    = 1'b1;
        comp_d[idx] = 1'b0;
        st_d[idx]   = disp_is_store_i[k];
        preg_d[idx] = disp_preg_i[k*PREG_W +: PREG_W];
        old_d[idx]  = disp_old_preg_i[k*PREG_W +: PREG_W];
      end
    end
    head_d  = head_q + TAG_W'(n_ret_c);
    tail_d  = tail_q + TAG_W'(n_disp_c);
    count_d = count_q + n_disp_c - n_ret_c;
    if (flush_c) begin
      v_d     = '0;
      comp_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q     <= '0;
      comp_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      comp_q  <= comp_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is only observed through valid entries, so it carries no reset.
  always_ff @(posedge clk) begin
    st_q   <= st_d;
    preg_q <= preg_d;
    old_q  <= old_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_rob_ring.sv
// tb_rob_ring: randomized + directed scoreboard bench for rob_ring against a queue-based ROB model.
// Define ROB_FLUSH_EN for both files to exercise the flush port.
`timescale 1ns/1ps
module tb_rob_ring;
  localparam int DEPTH = 16, DW = 2, CW = 3, RW = 2, PW = 6, XW = 32, TW = 4, NW = 5;

  typedef struct {
    logic          st;
    logic [PW-1:0] preg;
    logic [PW-1:0] old;
    logic          done;
    logic [XW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0]    disp_valid, disp_is_store, disp_ready;
  logic [DW*PW-1:0] disp_preg, disp_old_preg;
  logic [DW*TW-1:0] disp_tag;
  logic [CW-1:0]    cmpl_valid;
  logic [CW*TW-1:0] cmpl_tag;
  logic [CW*XW-1:0] cmpl_data;
  logic [RW-1:0]    ret_valid, ret_is_store, ret_free;
  logic [RW*PW-1:0] ret_old_preg, ret_preg;
  logic [RW*XW-1:0] ret_data;
  logic [NW-1:0]    count;

  logic [DW-1:0] s_dv, s_ds;
  logic [PW-1:0] s_p [DW];
  logic [PW-1:0] s_o [DW];
  logic [CW-1:0] s_cv;
  logic [TW-1:0] s_ct [CW];
  logic [XW-1:0] s_cd [CW];
  logic          s_fl;

  ent_t rob[$];
  ent_t exp_q[$];
  int   head_tag = 0;
  int   n_vec = 0;
  int   n_err = 0;

  rob_ring dut (
    .clk(clk), .reset(reset),
`ifdef ROB_FLUSH_EN
    .flush_i(s_fl),
`endif
    .disp_valid_i(disp_valid), .disp_is_store_i(disp_is_store),
    .disp_preg_i(disp_preg), .disp_old_preg_i(disp_old_preg),
    .disp_ready_o(disp_ready), .disp_tag_o(disp_tag),
    .cmpl_valid_i(cmpl_valid), .cmpl_tag_i(cmpl_tag), .cmpl_data_i(cmpl_data),
    .ret_valid_o(ret_valid), .ret_is_store_o(ret_is_store), .ret_free_o(ret_free),
    .ret_old_preg_o(ret_old_preg), .ret_preg_o(ret_preg), .ret_data_o(ret_data),
    .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    s_dv = '0; s_ds = '0; s_cv = '0; s_fl = 1'b0;
    for (int k = 0; k < DW; k++) begin s_p[k] = '0; s_o[k] = '0; end
    for (int p = 0; p < CW; p++) begin s_ct[p] = '0; s_cd[p] = '0; end
  endtask

  // One cycle, entered just after a falling edge; leaves at the next falling edge.
  task automatic step();
    int sz, nret, idx;
    logic ok;
    logic [DW-1:0] acc, rdy;
    logic [RW-1:0] rmask, fmask;
    logic [DW*TW-1:0] tags;
    sz = rob.size(); nret = 0; rmask = '0; fmask = '0;
    for (int j = 0; j < RW; j++) begin
      if (s_fl || j >= sz) break;
      if (!rob[j].done) break;
      exp_q.push_back(rob[j]);
      rmask[j] = 1'b1;
      fmask[j] = ~rob[j].st;
      nret++;
    end
    ok = 1'b1; tags = '0;
    for (int k = 0; k < DW; k++) begin
      rdy[k] = !s_fl && ((DEPTH - sz) > k);
      ok = ok && s_dv[k] && rdy[k];
      acc[k] = ok;
      tags[k*TW +: TW] = TW'((head_tag + sz + k) % DEPTH);
    end
    disp_valid = s_dv; disp_is_store = s_ds;
    disp_preg = {s_p[1], s_p[0]}; disp_old_preg = {s_o[1], s_o[0]};
    cmpl_valid = s_cv;
    cmpl_tag  = {s_ct[2], s_ct[1], s_ct[0]};
    cmpl_data = {s_cd[2], s_cd[1], s_cd[0]};
    #1;
    chk("count", count, sz);
    chk("disp_ready", disp_ready, rdy);
    chk("disp_tag", disp_tag, tags);
    chk("ret_valid", ret_valid, rmask);
    chk("ret_free", ret_free, fmask);
    @(posedge clk);
    for (int p = 0; p < CW; p++) begin
      if (s_cv[p]) begin
        idx = (int'(s_ct[p]) - head_tag + DEPTH) % DEPTH;
        if (idx < sz) begin rob[idx].done = 1'b1; rob[idx].data = s_cd[p]; end
      end
    end
    for (int j = 0; j < nret; j++) void'(rob.pop_front());
    head_tag = (head_tag + nret) % DEPTH;
    for (int k = 0; k < DW; k++)
      if (acc[k]) rob.push_back('{st: s_ds[k], preg: s_p[k], old: s_o[k], done: 1'b0, data: '0});
    if (s_fl) begin rob.delete(); head_tag = 0; end
    @(negedge clk);
  endtask

  task automatic rand_step(input int pinv);
    int pend[$];
    clr();
    s_dv = DW'($urandom); s_ds = DW'($urandom);
    for (int k = 0; k < DW; k++) begin s_p[k] = PW'($urandom); s_o[k] = PW'($urandom); end
    foreach (rob[i]) if (!rob[i].done) pend.push_back(i);
    for (int p = 0; p < CW; p++) begin
      s_cv[p] = ($urandom % 3) != 0;
      if (pend.size() > 0 && ($urandom % 100) >= pinv)
        s_ct[p] = TW'((head_tag + pend[$urandom % pend.size()]) % DEPTH);
      else
        s_ct[p] = TW'($urandom);
      s_cd[p] = $urandom;
    end
    step();
  endtask

  task automatic drain();
    int c;
    for (int n = 0; n < 40 && rob.size() > 0; n++) begin
      clr(); c = 0;
      foreach (rob[i]) begin
        if (!rob[i].done && c < CW) begin
          s_cv[c] = 1'b1; s_ct[c] = TW'((head_tag + i) % DEPTH); s_cd[c] = $urandom; c++;
        end
      end
      step();
    end
    clr(); step();
  endtask

  task automatic dispatch2(input logic [DW-1:0] dv, input logic [DW-1:0] ds);
    clr(); s_dv = dv; s_ds = ds;
    s_p[0] = PW'($urandom); s_p[1] = PW'($urandom); s_o[0] = PW'($urandom); s_o[1] = PW'($urandom);
    step();
  endtask

  // Scoreboard monitor: every retiring lane must match the next expected entry in order.
  initial begin
    ent_t me;
    forever begin
      @(negedge clk); #3;
      for (int j = 0; j < RW; j++) begin
        if (ret_valid[j]) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL ret_unexpected lane %0d: got a retire, expected none (t=%0t)", j, $time);
          end else begin
            me = exp_q.pop_front();
            chk($sformatf("ret_lane%0d", j),
                {19'd0, ret_is_store[j], ret_preg[j*PW +: PW], ret_old_preg[j*PW +: PW], ret_data[j*XW +: XW]},
                {19'd0, me.st, me.preg, me.old, me.data});
          end
        end
      end
    end
  end

  initial begin
    clr();
    disp_valid = '0; disp_is_store = '0; disp_preg = '0; disp_old_preg = '0;
    cmpl_valid = '0; cmpl_tag = '0; cmpl_data = '0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_disp_ready", disp_ready, 2'b11);
    chk("rst_disp_tag", disp_tag, 8'h10);
    chk("rst_ret", {ret_valid, ret_is_store, ret_free}, 0);
    chk("rst_ret_payload", {ret_preg, ret_old_preg}, 0);
    chk("rst_ret_data", ret_data, 0);
    @(negedge clk); reset = 1'b0;

    // Two lanes, complete both, retire together.
    clr(); s_dv = 2'b11; s_p[0] = 6'd33; s_p[1] = 6'd34; s_o[0] = 6'd1; s_o[1] = 6'd2; step();
    clr(); s_cv = 3'b011; s_ct[0] = 4'd0; s_ct[1] = 4'd1; s_cd[0] = 32'hA0; s_cd[1] = 32'hA1; step();
    clr(); step();
    clr(); step();

    // Invalid-tag completion ignored; out-of-order completion holds retire; same-tag highest port wins.
    dispatch2(2'b11, 2'b00);
    clr(); s_cv = 3'b011; s_ct[0] = 4'd9; s_ct[1] = 4'd3; s_cd[0] = 32'hDEAD; s_cd[1] = 32'h33; step();
    clr(); step();
    clr(); s_cv = 3'b111; s_ct[0] = 4'd2; s_ct[1] = 4'd2; s_ct[2] = 4'd2;
    s_cd[0] = 32'h1; s_cd[1] = 32'h2; s_cd[2] = 32'h22; step();
    clr(); step();
    clr(); step();

    // Fill to full, retire one, then a single lane reopens.
    for (int i = 0; i < 8; i++) dispatch2(2'b11, 2'($urandom));
    clr(); s_dv = 2'b11; s_cv = 3'b001; s_ct[0] = TW'(head_tag); s_cd[0] = 32'h44; step();
    clr(); s_dv = 2'b11; step();
    clr(); step();
    drain();

    // Store on lane 0, ALU op on lane 1.
    dispatch2(2'b11, 2'b01);
    clr(); s_cv = 3'b011; s_ct[0] = TW'(head_tag); s_ct[1] = TW'((head_tag + 1) % DEPTH);
    s_cd[0] = 32'h5; s_cd[1] = 32'h6; step();
    clr(); step();
    clr(); step();

    // Random traffic with wrap-around and occasional invalid-tag completions.
    for (int i = 0; i < 300; i++) rand_step(20);

    // Asynchronous reset mid-operation empties the buffer immediately.
    for (int i = 0; i < 4; i++) dispatch2(2'b11, 2'b00);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ret_valid", ret_valid, 0);
    chk("mid_rst_disp_ready", disp_ready, 2'b11);
    chk("mid_rst_disp_tag", disp_tag, 8'h10);
    rob.delete(); head_tag = 0;
    @(negedge clk); reset = 1'b0;

`ifdef ROB_FLUSH_EN
    dispatch2(2'b11, 2'b00);
    dispatch2(2'b11, 2'b00);
    clr(); s_dv = 2'b01; s_cv = 3'b001; s_ct[0] = 4'd0; s_cd[0] = 32'h77; step();
    clr(); s_fl = 1'b1; s_dv = 2'b11; s_cv = 3'b001; s_ct[0] = 4'd1; s_cd[0] = 32'h88; step();
    clr(); step();
`endif

    for (int i = 0; i < 120; i++) rand_step(30);
    drain();
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_count", count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
